// File: rtl/mm_back_end.sv
// mm_back_end: drains the result FIFO into the output memory, then holds done until start drops.
// Ports:
//   aclk, areset        clock and synchronous active-high reset
//   start, size         level job-active request and word count, sampled in IDLE
//   fifo_empty          result FIFO empty flag
//   fifo_dout           result FIFO data, valid one cycle after fifo_rd
//   fifo_rd             FIFO read strobe, combinational
//   mem_en, mem_we      registered memory enable and write enable
//   mem_addr, mem_din   registered memory write address and data
//   busy, done          high in RUN and in DONE respectively
//   wr_count            words written in the current job
module mm_back_end #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [ADDR_W:0]   size,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t          state, state_n;
    logic [ADDR_W:0] rd_cnt, wr_cnt, size_q;
    logic            pend;
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = !start ? IDLE : (size == '0 ? DONE : RUN);
            RUN:     state_n = !start ? IDLE : (wr_cnt == size_q ? DONE : RUN);
            DONE:    state_n = start ? DONE : IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign fifo_rd  = (state == RUN) && !fifo_empty && (rd_cnt < size_q) && start;
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign wr_count = wr_cnt;
    // pend marks a word whose FIFO data arrives this cycle; it is honoured even
    // after an abort so a popped word always reaches memory.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            size_q   <= '0;
            pend     <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state  <= state_n;
            pend   <= fifo_rd;
            mem_en <= pend;
            mem_we <= pend;
            if (state == IDLE && start) begin
                size_q <= size;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (fifo_rd)
                    rd_cnt <= rd_cnt + 1'b1;
                if (pend) begin
                    mem_addr <= wr_cnt[ADDR_W-1:0];
                    mem_din  <= fifo_dout;
                    wr_cnt   <= wr_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mm_back_end.sv
// tb_mm_back_end: table-driven and scoreboard bench for mm_back_end at ADDR_W=10 and ADDR_W=2.
module tb_mm_back_end;
    logic        aclk = 1'b0;
    logic        areset, start, gate, sel;
    logic [10:0] size;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        rd0, rd1, en0, en1, we0, we1, busy0, busy1, done0, done1;
    logic [9:0]  a0;
    logic [1:0]  a1;
    logic [31:0] d0, d1;
    logic [10:0] wc0;
    logic [2:0]  wc1;
    logic        s0, s1, fifo_rd, we_m, busy_m, done_m;
    logic [9:0]  addr_m;
    logic [31:0] din_m;
    logic [10:0] wc_m;

    logic [31:0] fmem [0:15];
    logic [3:0]  head = '0;
    logic [3:0]  tail = '0;
    int          cyc = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
    } ent_t;
    ent_t exp_q[$];

    typedef struct {
        logic        s;
        int          sz;
        int          pre;
        logic [15:0] g;
        int          exp_wc;
        int          exp_left;
    } vec_t;
    vec_t tbl [8];

    int tests, fails;
    int exp_idx, rd_count, rd_first, rd_last, last_we, done_cyc;
    int last_addr;
    bit done_seen;

    assign s0 = start & ~sel;
    assign s1 = start & sel;

    mm_back_end #(.ADDR_W(10), .DATA_W(32)) u0 (
        .aclk(aclk), .areset(areset), .start(s0), .size(size),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(rd0),
        .mem_en(en0), .mem_we(we0), .mem_addr(a0), .mem_din(d0),
        .busy(busy0), .done(done0), .wr_count(wc0)
    );

    mm_back_end #(.ADDR_W(2), .DATA_W(32)) u1 (
        .aclk(aclk), .areset(areset), .start(s1), .size(size[2:0]),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(rd1),
        .mem_en(en1), .mem_we(we1), .mem_addr(a1), .mem_din(d1),
        .busy(busy1), .done(done1), .wr_count(wc1)
    );

    assign fifo_rd    = rd0 | rd1;
    assign fifo_empty = gate || (head == tail);
    assign we_m       = sel ? we1 : we0;
    assign addr_m     = sel ? {8'b0, a1} : a0;
    assign din_m      = sel ? d1 : d0;
    assign busy_m     = sel ? busy1 : busy0;
    assign done_m     = sel ? done1 : done0;
    assign wc_m       = sel ? {8'b0, wc1} : wc0;

    always #5 aclk = ~aclk;

    // FIFO model: one-cycle read latency
    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            fifo_dout <= fmem[head];
            head      <= head + 1'b1;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++)
            fmem[4'(head + 4'(i))] = $urandom;
        tail = head + 4'(n);
    endtask

    task automatic new_job();
        exp_idx   = 0;
        rd_count  = 0;
        done_seen = 0;
        last_we   = -10;
        last_addr = -1;
    endtask

    task automatic sample();
        ent_t e;
        @(negedge aclk);
        if (we_m) begin
            if (exp_q.size() == 0)
                check("spurious_write", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("wr_addr", addr_m, e.addr);
                check("wr_data", din_m, e.data);
                check("wr_latency", cyc, e.cyc + 2);
                last_we   = cyc;
                last_addr = int'(addr_m);
            end
        end
        if (fifo_rd) begin
            e.addr = sel ? 10'(exp_idx % 4) : 10'(exp_idx % 1024);
            e.data = fmem[head];
            e.cyc  = cyc;
            exp_q.push_back(e);
            if (rd_count == 0)
                rd_first = cyc;
            rd_last = cyc;
            exp_idx++;
            rd_count++;
        end
        if (done_m && !done_seen) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
        if (areset)
            exp_q.delete();
    endtask

    task automatic step();
        sample();
        @(posedge aclk);
        #1;
    endtask

    task automatic run_job(input vec_t v);
        int sc;
        sel = v.s;
        load(v.pre);
        new_job();
        size  = 11'(v.sz);
        start = 1'b1;
        sc    = cyc;
        for (int c = 0; c < 200; c++) begin
            gate = (c < 16) ? v.g[c] : 1'b0;
            step();
            if (c == 0)
                check("busy", busy_m, v.sz != 0);
            if (done_seen)
                break;
        end
        gate = 1'b0;
        check("done_reached", done_seen, 1);
        check("wr_count", wc_m, v.exp_wc);
        check("reads", rd_count, v.sz);
        check("fifo_left", 4'(tail - head), v.exp_left);
        check("done_timing", done_cyc, v.sz == 0 ? sc + 1 : last_we + 1);
        if (v.sz > 1 && v.g == 16'h0)
            check("rd_burst", rd_last - rd_first, v.sz - 1);
        start = 1'b0;
        step();
        step();
        check("idle_done", done_m, 0);
        check("idle_busy", busy_m, 0);
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        areset = 1'b1;
        start  = 1'b0;
        gate   = 1'b0;
        sel    = 1'b0;
        size   = '0;
        new_job();
        tbl[0] = '{1'b0, 4, 4, 16'h0000, 4, 0};
        tbl[1] = '{1'b0, 3, 3, 16'h001A, 3, 0};
        tbl[2] = '{1'b0, 2, 5, 16'h0000, 2, 3};
        tbl[3] = '{1'b0, 0, 2, 16'h0000, 0, 2};
        tbl[4] = '{1'b0, 1, 1, 16'h00FE, 1, 0};
        tbl[5] = '{1'b1, 4, 4, 16'h0000, 4, 0};
        tbl[6] = '{1'b1, 4, 6, 16'h0014, 4, 2};
        tbl[7] = '{1'b0, 6, 6, 16'h0AAA, 6, 0};
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_mem_en", en0, 0);
        check("rst_mem_we", we0, 0);
        check("rst_mem_addr", a0, 0);
        check("rst_mem_din", d0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_wr_count", wc0, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        step();

        for (int i = 0; i < 8; i++)
            run_job(tbl[i]);

        // abort after the third read
        sel = 1'b0;
        load(8);
        new_job();
        size  = 11'd8;
        start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (rd_count >= 3)
                break;
        end
        start = 1'b0;
        repeat (5) step();
        check("abort_reads", rd_count, 3);
        check("abort_last_addr", last_addr, 2);
        check("abort_wr_count", wc0, 3);
        check("abort_busy", busy0, 0);
        check("abort_done_seen", done_seen, 0);
        check("abort_fifo_left", 4'(tail - head), 5);
        check("abort_drained", exp_q.size(), 0);

        run_job('{1'b0, 2, 2, 16'h0000, 2, 0});

        // reset while a popped word is pending
        load(8);
        new_job();
        size  = 11'd8;
        start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (rd_count >= 2)
                break;
        end
        areset = 1'b1;
        start  = 1'b0;
        step();
        step();
        areset = 1'b0;
        check("mrst_fifo_rd", fifo_rd, 0);
        check("mrst_mem_we", we0, 0);
        check("mrst_mem_addr", a0, 0);
        check("mrst_mem_din", d0, 0);
        check("mrst_busy", busy0, 0);
        check("mrst_done", done0, 0);
        check("mrst_wr_count", wc0, 0);
        repeat (3) step();
        check("mrst_no_write", we0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
